// File: rtl/sub_pkg.sv
// Shared width default and result record for the pipelined subtractor.
package sub_pkg;

    localparam int SUB_WIDTH = 16;

    typedef struct packed {
        logic [SUB_WIDTH-1:0] diff;
        logic                 bout;
        logic                 overflow;
    } sub_result_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract slice: d = x - y - bi, bo = borrow out.
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    logic [W:0] full;

    // One extra bit catches the borrow: it is set exactly when x < y + bi.
    assign full    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    assign {bo, d} = full;

endmodule

// File: rtl/sub_16bit_pipe.sv
// Two-stage subtractor: low slice in stage 1, high slice plus flags in stage 2,
// with a valid/ready skid-free pipeline that holds up to two beats.
module sub_16bit_pipe
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int HI_W = WIDTH - LO_W;

    logic            s1_valid;
    logic [LO_W-1:0] s1_lo;
    logic            s1_blo;
    logic [HI_W-1:0] s1_a_hi;
    logic [HI_W-1:0] s1_b_hi;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_diff;
    logic             s2_bout;
    logic             s2_ovf;

    logic            s1_adv;
    logic            s2_adv;
    logic [LO_W-1:0] lo_d;
    logic            lo_bo;
    logic [HI_W-1:0] hi_d;
    logic            hi_bo;
    logic            hi_ovf;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rst_n && s1_adv;

    sub_slice #(.W(LO_W)) u_slice_lo (
        .x  (a[LO_W-1:0]),
        .y  (b[LO_W-1:0]),
        .bi (bin),
        .d  (lo_d),
        .bo (lo_bo)
    );

    sub_slice #(.W(HI_W)) u_slice_hi (
        .x  (s1_a_hi),
        .y  (s1_b_hi),
        .bi (s1_blo),
        .d  (hi_d),
        .bo (hi_bo)
    );

    // Operands of opposite sign whose result sign departs from the minuend.
    assign hi_ovf = (s1_a_hi[HI_W-1] != s1_b_hi[HI_W-1]) &&
                    (hi_d[HI_W-1] != s1_a_hi[HI_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_blo   <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo   <= lo_d;
                s1_blo  <= lo_bo;
                s1_a_hi <= a[WIDTH-1:LO_W];
                s1_b_hi <= b[WIDTH-1:LO_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_diff  <= '0;
            s2_bout  <= 1'b0;
            s2_ovf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_diff <= {hi_d, s1_lo};
                s2_bout <= hi_bo;
                s2_ovf  <= hi_ovf;
            end
        end
    end

    assign out_valid = s2_valid;
    assign diff      = s2_diff;
    assign bout      = s2_bout;
    assign overflow  = s2_ovf;

endmodule
